pipe_regfile: RTL and testbench

Parametrised, writable register file for the pipelined datapath; the successor to the fixed read-only 16×8 operand table. It provides NUM_RD combinational read ports, one synchronous write port from writeback, and a per-register busy scoreboard so decode can detect operands still in flight. Contents reset to an identity pattern, so the ISA-visible state after reset is unchanged: register i holds i.

---
 rtl/pipe_regfile_pkg.sv | 17 +
 rtl/pipe_regfile_if.sv | 33 +++
 rtl/pipe_regfile_scoreboard.sv | 52 +++++
 rtl/pipe_regfile.sv | 69 ++++++
 tb/tb_pipe_regfile.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : default geometry and shared types for pipe_regfile
// Rev 1.0
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/pipe_regfile_if.sv
`default_nettype none
// ============================================================================
// pipe_regfile_if : read, writeback and reservation bus of pipe_regfile
// Rev 1.0
// ============================================================================
interface pipe_regfile_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 3
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ready
  );
endinterface
`default_nettype wire

// File: rtl/pipe_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : per-register busy bits, set on reservation, cleared on writeback
// Rev 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 3,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     wr_en_i,
  input  wire logic [ADDR_W-1:0]        wr_addr_i,
  input  wire logic                     rsv_en_i,
  input  wire logic [ADDR_W-1:0]        rsv_addr_i,
  input  wire logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic      [NUM_RD-1:0]        rd_busy_o,
  output logic                          rsv_ready_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  assign rsv_ready_o = (rsv_addr_i == '0) || !busy_q[rsv_addr_i];

  // Set is applied after clear so a same-address reservation wins over writeback.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (rsv_en_i && rsv_ready_o) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    assign rd_busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
  end

endmodule
`default_nettype wire

// File: rtl/pipe_regfile.sv
`default_nettype none
// ============================================================================
// pipe_regfile : NUM_RD-read / 1-write register file with busy scoreboard
// Optional write-through forwarding: define PIPE_REGFILE_BYPASS_EN.  Rev 1.0
// ============================================================================
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input wire logic     clk,
  input wire logic     rst,
  pipe_regfile_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_RD-1:0] sb_busy;

  // Identity reset keeps ISA-visible state equal to the old read-only table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (bus.wr_en),
    .wr_addr_i   (bus.wr_addr),
    .rsv_en_i    (bus.rsv_en),
    .rsv_addr_i  (bus.rsv_addr),
    .rd_addr_i   (bus.rd_addr),
    .rd_busy_o   (sb_busy),
    .rsv_ready_o (bus.rsv_ready)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;

    assign addr   = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign stored = mem_q[addr];

`ifdef PIPE_REGFILE_BYPASS_EN
    logic hit;
    assign hit = bus.wr_en && (bus.wr_addr == addr) && (addr != '0);
    assign bus.rd_data[k*DATA_W +: DATA_W] = hit ? bus.wr_data : stored;
    assign bus.rd_busy[k] = sb_busy[k] & ~hit;
`else
    assign bus.rd_data[k*DATA_W +: DATA_W] = stored;
    assign bus.rd_busy[k] = sb_busy[k];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_regfile.sv
`default_nettype none
// ============================================================================
// tb_pipe_regfile : directed vector table, corner sequences and random run vs model
// Rev 1.0
// ============================================================================
module tb_pipe_regfile;
  import regfile_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int NR = 3;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_regfile_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) bus ();

  pipe_regfile #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        chk;
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        re;
    logic [3:0]  ra;
    logic [11:0] rda;   // {port2, port1, port0}
    logic [23:0] ed;    // {port2, port1, port0}
    logic [2:0]  eb;
    logic        er;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  reg_data_t m_mem  [DP];
  logic      m_busy [DP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic we, input reg_addr_t wa, input reg_data_t wd,
                       input logic re, input reg_addr_t ra, input logic [11:0] rda);
    rst          = r;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = ra;
    bus.rd_addr  = rda;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) begin
      m_mem[i]  = reg_data_t'(i);
      m_busy[i] = 1'b0;
    end
  endtask

  // Compares current outputs with what the model predicts for the applied inputs.
  task automatic model_check();
    reg_addr_t a;
    reg_data_t ed;
    logic      eb;
    logic      er;
    for (int k = 0; k < NR; k++) begin
      a  = bus.rd_addr[k*AW +: AW];
      ed = (a == 0) ? 8'h00 : m_mem[a];
      eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef PIPE_REGFILE_BYPASS_EN
      if (bus.wr_en && bus.wr_addr == a && a != 0) begin
        ed = bus.wr_data;
        eb = 1'b0;
      end
`endif
      chk("rnd_rd_data", 32'(bus.rd_data[k*DW +: DW]), 32'(ed));
      chk("rnd_rd_busy", 32'(bus.rd_busy[k]), 32'(eb));
    end
    er = (bus.rsv_addr == 0) || !m_busy[bus.rsv_addr];
    chk("rnd_rsv_ready", 32'(bus.rsv_ready), 32'(er));
  endtask

  task automatic model_edge();
    logic ready;
    ready = (bus.rsv_addr == 0) || !m_busy[bus.rsv_addr];
    if (rst) begin
      model_reset();
    end else begin
      if (bus.wr_en && bus.wr_addr != 0) begin
        m_mem[bus.wr_addr]  = bus.wr_data;
        m_busy[bus.wr_addr] = 1'b0;
      end
      if (bus.rsv_en && ready && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
    end
  endtask

  initial begin
    //        chk rst we wa     wd     re ra     rda {p2,p1,p0}          ed {p2,p1,p0}               eb      er
    vt[0]  = '{0, 1, 0, 4'd0, 8'h00, 0, 4'd0, {4'd0, 4'd0,  4'd0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1};
    vt[1]  = '{1, 0, 1, 4'd7, 8'hA5, 0, 4'd0, {4'd0, 4'd15, 4'd3}, {8'h00, 8'h0F, 8'h03}, 3'b000, 1};
    vt[2]  = '{1, 0, 1, 4'd0, 8'hFF, 0, 4'd0, {4'd0, 4'd0,  4'd7}, {8'h00, 8'h00, 8'hA5}, 3'b000, 1};
    vt[3]  = '{1, 0, 0, 4'd0, 8'h00, 1, 4'd4, {4'd0, 4'd0,  4'd0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1};
    vt[4]  = '{1, 0, 0, 4'd0, 8'h00, 1, 4'd4, {4'd0, 4'd0,  4'd4}, {8'h00, 8'h00, 8'h04}, 3'b001, 0};
    vt[5]  = '{1, 0, 1, 4'd4, 8'h3C, 0, 4'd4, {4'd3, 4'd2,  4'd1}, {8'h03, 8'h02, 8'h01}, 3'b000, 0};
    vt[6]  = '{1, 0, 1, 4'd5, 8'hAA, 1, 4'd5, {4'd0, 4'd0,  4'd4}, {8'h00, 8'h00, 8'h3C}, 3'b000, 1};
    vt[7]  = '{1, 0, 0, 4'd0, 8'h00, 0, 4'd5, {4'd5, 4'd0,  4'd0}, {8'hAA, 8'h00, 8'h00}, 3'b100, 0};
    vt[8]  = '{1, 0, 0, 4'd0, 8'h00, 1, 4'd2, {4'd0, 4'd0,  4'd0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1};
    vt[9]  = '{1, 0, 0, 4'd0, 8'h00, 1, 4'd6, {4'd0, 4'd0,  4'd2}, {8'h00, 8'h00, 8'h02}, 3'b001, 1};
    vt[10] = '{1, 0, 1, 4'd6, 8'h77, 0, 4'd6, {4'd0, 4'd2,  4'd0}, {8'h00, 8'h02, 8'h00}, 3'b010, 0};
    vt[11] = '{1, 1, 0, 4'd0, 8'h00, 0, 4'd2, {4'd6, 4'd2,  4'd0}, {8'h77, 8'h02, 8'h00}, 3'b010, 0};
    vt[12] = '{1, 0, 0, 4'd0, 8'h00, 0, 4'd2, {4'd6, 4'd2,  4'd0}, {8'h06, 8'h02, 8'h00}, 3'b000, 1};
    vt[13] = '{1, 0, 0, 4'd0, 8'h00, 0, 4'd6, {4'd0, 4'd0,  4'd6}, {8'h00, 8'h00, 8'h06}, 3'b000, 1};

    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, vt[i].rda);
      #3;
      if (vt[i].chk) begin
        chk($sformatf("vec%0d_rd_data", i), 32'(bus.rd_data), 32'(vt[i].ed));
        chk($sformatf("vec%0d_rd_busy", i), 32'(bus.rd_busy), 32'(vt[i].eb));
        chk($sformatf("vec%0d_rsv_ready", i), 32'(bus.rsv_ready), 32'(vt[i].er));
      end
      next_cycle();
    end

    // Same-cycle write and read of r9: forwarded only in the bypass build.
    drive(1'b0, 1'b1, 4'd9, 8'h11, 1'b0, 4'd0, {4'd0, 4'd0, 4'd9});
    #3;
`ifdef PIPE_REGFILE_BYPASS_EN
    chk("bypass_same_cycle", 32'(bus.rd_data[7:0]), 32'h11);
`else
    chk("nobypass_same_cycle", 32'(bus.rd_data[7:0]), 32'h09);
`endif
    chk("bypass_busy", 32'(bus.rd_busy[0]), 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, {4'd0, 4'd0, 4'd9});
    #3;
    chk("write_next_cycle", 32'(bus.rd_data[7:0]), 32'h11);
    next_cycle();

    // Reset overrides a same-cycle write and reservation.
    drive(1'b1, 1'b1, 4'd3, 8'h55, 1'b1, 4'd3, {4'd0, 4'd0, 4'd3});
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 4'd3, {4'd0, 4'd9, 4'd3});
    #3;
    chk("rst_over_write", 32'(bus.rd_data), 32'h000903);
    chk("rst_over_rsv_busy", 32'(bus.rd_busy), 32'h0);
    chk("rst_over_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    next_cycle();

    // Randomised run against the behavioural model.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    model_edge();
    next_cycle();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 2) == 0),
            reg_addr_t'($urandom_range(0, DP - 1)),
            reg_data_t'($urandom),
            ($urandom_range(0, 1) == 0),
            reg_addr_t'($urandom_range(0, DP - 1)),
            12'($urandom));
      #3;
      if (!rst) model_check();
      model_edge();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
